// File: rtl/mac_sequencer.sv
// Purpose: drives one MAC accumulator through a length-N vector of data/weight pairs, then returns the sum.
// Latency: N+2 cycles from start to out_valid with no bubbles; a zero-length command returns 0 after one cycle.
// Backpressure: in_ready is high only while feeding pairs; out_valid/out_data hold until out_ready.
module mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_weight,
  output logic [DATA_W-1:0] mac_data,
  output logic [DATA_W-1:0] mac_weight,
  output logic              mac_enable,
  output logic              mac_clear,
  input  logic [ACC_W-1:0]  mac_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FEED    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   count, count_nxt;
  logic [DATA_W-1:0]  mac_data_nxt, mac_weight_nxt;
  logic               mac_enable_nxt, mac_clear_nxt;
  logic               out_valid_nxt, done_nxt;
  logic [ACC_W-1:0]   out_data_nxt;
  logic               pair_xfer;

  // Ready and busy decode straight from state so an async reset drops them at once.
  assign in_ready  = (state == FEED);
  assign busy      = (state != IDLE);
  assign pair_xfer = in_valid && in_ready;

  // State and registered-output update; everything returns to zero on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      mac_data   <= '0;
      mac_weight <= '0;
      mac_enable <= 1'b0;
      mac_clear  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      mac_data   <= mac_data_nxt;
      mac_weight <= mac_weight_nxt;
      mac_enable <= mac_enable_nxt;
      mac_clear  <= mac_clear_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      done       <= done_nxt;
    end
  end

  // Next-state and next-output decode; pulses default low, held values default to current.
  always_comb begin
    state_nxt      = state;
    count_nxt      = count;
    mac_data_nxt   = mac_data;
    mac_weight_nxt = mac_weight;
    mac_enable_nxt = 1'b0;
    mac_clear_nxt  = 1'b0;
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    done_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            count_nxt = len;
            state_nxt = FEED;
          end else begin
            // Empty vector: answer 0 without touching the MAC.
            out_data_nxt  = '0;
            out_valid_nxt = 1'b1;
            state_nxt     = OUTPUT;
          end
        end
      end

      FEED: begin
        if (pair_xfer) begin
          mac_data_nxt   = in_data;
          mac_weight_nxt = in_weight;
          mac_enable_nxt = 1'b1;
          count_nxt      = count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state_nxt = SETTLE;
          end
        end
      end

      // Last pair's enable is live this cycle; the MAC adds it at the closing edge.
      SETTLE: begin
        state_nxt = CAPTURE;
      end

      // MAC output is now final: take it and clear the MAC for the next vector.
      CAPTURE: begin
        out_data_nxt  = mac_result;
        out_valid_nxt = 1'b1;
        mac_clear_nxt = 1'b1;
        state_nxt     = OUTPUT;
      end

      OUTPUT: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a behavioural MAC is attached, results are scoreboarded,
// timing, pulse counts, output hold and reset behaviour are checked.
module tb_mac_sequencer;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 17;
  localparam int LEN_W  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] in_weight = '0;
  logic [DATA_W-1:0] mac_data;
  logic [DATA_W-1:0] mac_weight;
  logic              mac_enable;
  logic              mac_clear;
  logic [ACC_W-1:0]  mac_result;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;
  logic              busy;
  logic              done;

  mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .mac_data(mac_data), .mac_weight(mac_weight), .mac_enable(mac_enable), .mac_clear(mac_clear),
    .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Behavioural accumulator standing in for the MAC instance.
  logic [ACC_W-1:0] acc;
  always @(posedge clock or posedge reset) begin
    if (reset)           acc <= '0;
    else if (mac_clear)  acc <= '0;
    else if (mac_enable) acc <= acc + ({9'd0, mac_data} * {9'd0, mac_weight});
  end
  assign mac_result = acc;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int enable_cnt = 0;
  int clear_cnt = 0;
  int exp_q[$];
  logic [DATA_W-1:0] pd [0:15];
  logic [DATA_W-1:0] pw [0:15];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops, done pulse timing, output hold under backpressure, pulse counting.
  logic             hs_prev = 1'b0;
  logic             held_prev = 1'b0;
  logic [ACC_W-1:0] held_data = '0;
  always @(negedge clock) begin
    if (reset) begin
      hs_prev   <= 1'b0;
      held_prev <= 1'b0;
    end else begin
      if (mac_enable) enable_cnt++;
      if (mac_clear)  clear_cnt++;
      if (hs_prev || done) check("done_pulse", done, hs_prev);
      if (held_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", out_data, exp_q.pop_front());
      end
      hs_prev   <= out_valid && out_ready;
      held_prev <= out_valid && !out_ready;
      held_data <= out_data;
    end
  end

  // One complete command. Forced bubbles: bub_n idle cycles before pair bub_idx.
  task automatic do_op(input int n, input int bub_idx, input int bub_n,
                       input int bubble_pct, input int stall, input bit sb);
    int exp_sum, i, guard, bubbles, forced, c0, lat, en0, clr0;
    bit go, accepted, sb_done;
    exp_sum = 0;
    for (int k = 0; k < n; k++) exp_sum += int'(pd[k]) * int'(pw[k]);
    exp_q.push_back(exp_sum % (1 << ACC_W));
    en0 = enable_cnt; clr0 = clear_cnt;
    out_ready = (stall == 0);
    start = 1'b1; len = LEN_W'(n);
    @(posedge clock); #1;
    start = 1'b0;
    c0 = cyc;
    i = 0; guard = 0; bubbles = 0; forced = 0; sb_done = 1'b0;
    while (i < n && guard < 300) begin
      go = 1'b1;
      if (i == bub_idx && forced < bub_n) begin
        go = 1'b0; forced++;
      end else if (int'($urandom_range(99)) < bubble_pct) begin
        go = 1'b0;
      end
      in_valid = go; in_data = pd[i]; in_weight = pw[i];
      start = sb && !sb_done && (i == 1);
      if (start) begin
        sb_done = 1'b1; len = LEN_W'(7);
      end
      accepted = go && in_ready;
      if (!go) bubbles++;
      @(posedge clock); #1;
      if (accepted) i++;
      guard++;
    end
    in_valid = 1'b0; start = 1'b0;
    if (guard >= 300) check("feed_timeout", i, n);
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(posedge clock); #1; guard++;
    end
    check("out_valid_seen", out_valid, 1);
    lat = cyc - c0;
    check("latency", lat, (n == 0) ? 0 : n + 2 + bubbles);
    for (int s = 0; s < stall; s++) begin
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    guard = 0;
    while (out_valid && guard < 10) begin
      @(posedge clock); #1; guard++;
    end
    check("valid_dropped", out_valid, 0);
    check("idle_after_hs", busy, 0);
    check("enable_pulses", enable_cnt - en0, n);
    check("clear_pulses", clear_cnt - clr0, (n == 0) ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset state, held across a clock edge.
    @(posedge clock); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mac_enable", mac_enable, 0);
    check("rst_mac_clear", mac_clear, 0);
    check("rst_mac_data", {mac_data, mac_weight}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #2 reset = 1'b0;
    @(posedge clock); #1;

    // Three pairs back-to-back: 6+20+100.
    pd[0] = 8'd2;  pw[0] = 8'd3;
    pd[1] = 8'd4;  pw[1] = 8'd5;
    pd[2] = 8'd10; pw[2] = 8'd10;
    do_op(3, -1, 0, 0, 0, 1'b0);

    // Full-scale pair of products, no wrap.
    pd[0] = 8'd255; pw[0] = 8'd255;
    pd[1] = 8'd255; pw[1] = 8'd255;
    do_op(2, -1, 0, 0, 0, 1'b0);

    // Empty vector.
    do_op(0, -1, 0, 0, 0, 1'b0);

    // Mid-vector bubbles, consumer stall, stray start while busy.
    pd[0] = 8'd11; pw[0] = 8'd13;
    pd[1] = 8'd200; pw[1] = 8'd3;
    pd[2] = 8'd17; pw[2] = 8'd19;
    pd[3] = 8'd1;  pw[3] = 8'd250;
    do_op(4, 2, 2, 0, 5, 1'b1);

    // Consecutive ops prove the clear pulse isolates results.
    pd[0] = 8'd7; pw[0] = 8'd7;
    do_op(1, -1, 0, 0, 0, 1'b0);
    pd[0] = 8'd1; pw[0] = 8'd1;
    do_op(1, -1, 0, 0, 0, 1'b0);

    // Reset after two of five pairs: everything zero at once, no result.
    start = 1'b1; len = LEN_W'(5);
    @(posedge clock); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'd9; in_weight = 8'd9;
    @(posedge clock); #1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("pre_rst_enable", mac_enable, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_enable", mac_enable, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out", {out_valid, done, mac_clear}, 0);
    check("mid_rst_data", {mac_data, mac_weight}, 0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    pd[0] = 8'd3; pw[0] = 8'd3;
    do_op(1, -1, 0, 0, 0, 1'b0);

    // Randomized commands with random bubbles and stalls.
    for (int r = 0; r < 24; r++) begin
      n = (r % 6 == 5) ? 0 : int'($urandom_range(8, 1));
      for (int k = 0; k < 16; k++) begin
        pd[k] = DATA_W'($urandom_range(127));
        pw[k] = DATA_W'($urandom_range(127));
      end
      do_op(n, -1, 0, 30, int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Initiator-side controller for the `digital_MAC` accumulator port. It accepts a start command with a vector length and takes that many data/weight pairs over a valid/ready stream. It drives the MAC's `data_in`, `weight_in` and `enable` pins with one registered enable pulse per pair. When the vector completes it captures the 17-bit accumulated `data_out`, clears the MAC through its reset pin and presents the result on a valid/ready output. It sits between the layer-level controller and one MAC instance, replacing the bench-driven MULT/CHECK_ACCUM sequence.

## Interface
- `DATA_W`, 8, data and weight width; matches the MAC inputs.
- `ACC_W`, 17, accumulator and result width; matches the MAC `data_out`.
- `LEN_W`, 8, width of the vector-length field.

- `clock`  in  1  single system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- `start`  in  1  command strobe; sampled only in IDLE.
- `len`  in  LEN_W  number of pairs; sampled with `start`.
- `in_valid`  in  1  pair available.
- `in_ready`  out  1  sequencer accepts a pair this cycle.
- `in_data`  in  DATA_W  activation operand.
- `in_weight`  in  DATA_W  weight operand.
- `mac_data`  out  DATA_W  to MAC `data_in`; registered.
- `mac_weight`  out  DATA_W  to MAC `weight_in`; registered.
- `mac_enable`  out  1  to MAC `enable`; registered, one cycle per accepted pair.
- `mac_clear`  out  1  to MAC `reset`; registered, one-cycle pulse.
- `mac_result`  in  ACC_W  from MAC `data_out`.
- `out_valid`  out  1  result held valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  ACC_W  captured accumulation.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on the cycle after the output handshake.

## Operation
- **Reset values.** All outputs are 0: `in_ready`, `mac_*`, `out_valid`, `out_data`, `busy` and `done`. The state is IDLE and the pair counter is 0.
- **IDLE.** `in_ready` = 0.
  - On `start` with `len` ≠ 0: latch `len` into the counter and go to FEED.
  - On `start` with `len` = 0: set `out_data` to 0 and `out_valid` to 1, and go to OUTPUT. No enable or clear pulse is issued.
- **FEED.** `in_ready` = 1.
  - On `in_valid` && `in_ready`: register `mac_data` ← `in_data`, `mac_weight` ← `in_weight` and `mac_enable` ← 1, then decrement the counter.
  - Cycles with no transfer register `mac_enable` ← 0. `mac_data` and `mac_weight` hold their values.
  - On the transfer where the counter is 1, go to SETTLE.
- **SETTLE.** One cycle; `in_ready` = 0. `mac_enable` is high for the last pair, and the MAC accumulates at the end of this cycle. `mac_enable` ← 0. Go to CAPTURE.
- **CAPTURE.** One cycle; `mac_result` is stable.
  - Register `out_data` ← `mac_result`, `out_valid` ← 1 and `mac_clear` ← 1.
  - Go to OUTPUT.
- **OUTPUT.**
  - `mac_clear` is deasserted after its first cycle.
  - `out_valid` and `out_data` are held until `out_ready`.
  - On `out_valid` && `out_ready`: `out_valid` ← 0, `done` ← 1 for one cycle, go to IDLE.
- **Ignored inputs.** `start` outside IDLE is ignored; it is neither queued nor errored. `in_valid` outside FEED is ignored, because `in_ready` = 0.
- **Arithmetic.** There is none in the sequencer; the result is passed through at ACC_W bits. The MAC's full-scale range covers two 255×255 products: 130050 < 2^17.
- **Result isolation.** Each operation starts from a cleared MAC, because of the clear pulse in the previous op or the system reset. The MAC must also be reset by the system `reset`.
- **Reset mid-operation.** The sequencer returns to IDLE asynchronously and `mac_enable` drops immediately. Partial MAC contents are cleared by the shared system reset, and no result or `done` is produced.

## Timing
- **Handshake to accumulation.** A pair accepted at edge k has `mac_enable` high during cycle k+1. The MAC adds it at edge k+1.
- **Command to result.** `start` is sampled at edge e0 and N pairs are accepted back-to-back at edges e1..eN. SETTLE follows eN, then CAPTURE after eN+1. `out_valid` and `mac_clear` rise after eN+2.
- **End to end.** Minimum command-to-result latency is N+2 cycles. Minimum command-to-IDLE latency is N+3 cycles, with `out_ready` tied high.
- **len = 0.** `out_valid` rises one cycle after `start`.
- **Bubbles.** Each cycle with `in_valid` low during FEED adds exactly one cycle.
- **Back-to-back commands.** A new `start` is accepted on the first IDLE cycle, which coincides with the `done` pulse.

## Test plan
- len=3, pairs (2,3),(4,5),(10,10) back-to-back, `out_ready`=1 -> exactly three `mac_enable` pulses, `out_data`=126 at start+5, `done` one cycle later.
- len=2, pairs (255,255) ×2 -> `out_data`=130050, no wrap.
- len=0 -> `out_data`=0 and `out_valid` one cycle after `start`; no `mac_enable` or `mac_clear` pulse.
- len=4 with `in_valid` low for 2 cycles mid-vector, plus `out_ready` low for 5 cycles -> correct sum; `out_valid` and `out_data` stable throughout the stall; `start` pulsed while busy is ignored.
- Two consecutive ops, first (7,7)=49, then (1,1) -> second `out_data`=1, proving the clear pulse.
- Assert `reset` during FEED after 2 of 5 pairs -> all outputs 0 immediately, state IDLE, no `done`; a following len=1 op with (3,3) gives 9.
